// File: rtl/rsa_keygen_ctrl.sv
// rsa_keygen_ctrl: sequences toy RSA key generation (n, phi, gcd check, external modular inverse)
// Ports: clk/rst_n clock and async active-low reset; start with p, q, e request a run;
// inv_start/inv_a/inv_b drive the external inverse engine, inv_done/inv_out return its result;
// n, phi, d are the results; busy/done/err report status and err_code the failure cause.
module rsa_keygen_ctrl #(
  parameter int TIMEOUT = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  p,
  input  logic [7:0]  q,
  input  logic [7:0]  e,
  output logic        inv_start,
  output logic [7:0]  inv_a,
  output logic [7:0]  inv_b,
  input  logic        inv_done,
  input  logic [7:0]  inv_out,
  output logic [15:0] n,
  output logic [15:0] phi,
  output logic [7:0]  d,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, GCD, INV_REQ, INV_WAIT, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [7:0] r_p, r_q, r_e, r_x, r_y, r_d;
  logic [15:0] r_n, r_phi;
  logic [1:0] r_err_code;
  logic [CW-1:0] r_cnt;
  logic w_bad, w_tmo;
  assign w_bad = r_p < 8'd2 || r_q < 8'd2 || r_e < 8'd2 || r_phi > 16'd255 || {8'd0, r_e} >= r_phi;
  // The counter is 0 in the first INV_WAIT cycle, so this fires in the TIMEOUT-th wait cycle
  // and ERR is entered TIMEOUT clock edges after the edge that samples inv_start.
  assign w_tmo = r_cnt == CW'(TIMEOUT - 1);
  assign n = r_n;
  assign phi = r_phi;
  assign d = r_d;
  assign err_code = r_err_code;
  // Operands come straight from the captured e and registered phi, so they stay still for the whole request.
  assign inv_a = r_e;
  assign inv_b = r_phi[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy = r_state != IDLE;
    done = r_state == DONE;
    err = r_state == ERR;
    inv_start = r_state == INV_REQ;
    case (r_state)
      IDLE:     w_next = start ? LOAD : IDLE;
      LOAD:     w_next = CHECK;
      CHECK:    w_next = w_bad ? ERR : GCD;
      GCD:      w_next = r_x != r_y ? GCD : r_x == 8'd1 ? INV_REQ : ERR;
      INV_REQ:  w_next = INV_WAIT;
      INV_WAIT: w_next = inv_done ? DONE : w_tmo ? ERR : INV_WAIT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p <= '0;
      r_q <= '0;
      r_e <= '0;
      r_x <= '0;
      r_y <= '0;
      r_d <= '0;
      r_n <= '0;
      r_phi <= '0;
      r_err_code <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_p <= p;
          r_q <= q;
          r_e <= e;
        end
        LOAD: begin
          r_n <= {8'd0, r_p} * {8'd0, r_q};
          r_phi <= {8'd0, r_p - 8'd1} * {8'd0, r_q - 8'd1};
          r_d <= '0;
          r_err_code <= '0;
        end
        CHECK: if (w_bad) r_err_code <= 2'b01;
        else begin
          r_x <= r_e;
          r_y <= r_phi[7:0];
        end
        GCD: if (r_x > r_y) r_x <= r_x - r_y;
        else if (r_y > r_x) r_y <= r_y - r_x;
        else if (r_x != 8'd1) r_err_code <= 2'b10;
        INV_REQ: r_cnt <= '0;
        INV_WAIT: if (inv_done) r_d <= inv_out;
        else if (w_tmo) r_err_code <= 2'b11;
        else r_cnt <= r_cnt + CW'(1);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// tb_rsa_keygen_ctrl: directed scoreboard bench for rsa_keygen_ctrl with a behavioural inverse engine
module tb_rsa_keygen_ctrl;
  localparam int TO = 300;
  logic clk = 0, rst_n = 1, start = 0, inv_done = 0;
  logic [7:0] p = 0, q = 0, e = 0, inv_out = 0;
  logic inv_start, busy, done, err;
  logic [7:0] inv_a, inv_b, d;
  logic [15:0] n, phi;
  logic [1:0] err_code;
  typedef struct {logic is_err; logic [1:0] code; logic [15:0] n; logic [15:0] phi; logic [7:0] d;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, errors = 0, cyc = 0, lat = 0, t0 = 0;
  int done_cnt = 0, err_cnt = 0, istart_cnt = 0, t_istart = 0, t_end = 0;
  logic [7:0] eng_val = 0, seen_a = 0, seen_b = 0, done_a = 0, done_b = 0;
  logic stray = 0;

  rsa_keygen_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p(p), .q(q), .e(e),
    .inv_start(inv_start), .inv_a(inv_a), .inv_b(inv_b), .inv_done(inv_done), .inv_out(inv_out),
    .n(n), .phi(phi), .d(d), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int inv_of(input int a, input int m);
    for (int i = 1; i < m; i++) if ((a * i) % m == 1) return i;
    return 0;
  endfunction

  function automatic int gcd_steps(input int a, input int b);
    int s = 0;
    while (a != b) begin
      if (a > b) a -= b;
      else b -= a;
      s++;
    end
    return s;
  endfunction

  // Inverse engine: answers lat cycles after seeing inv_start (lat=0 never answers);
  // stray injects one inv_done pulse while the controller is not waiting.
  initial begin
    int rem;
    bit pend;
    pend = 0;
    rem = 0;
    forever begin
      @(negedge clk);
      inv_done = 0;
      if (pend && rem == 1) begin
        inv_done = 1;
        inv_out = eng_val;
        done_a = inv_a;
        done_b = inv_b;
        pend = 0;
      end else if (pend) rem--;
      if (stray) begin
        inv_done = 1;
        inv_out = 8'hAA;
        stray = 0;
      end
      if (inv_start && lat > 0) begin
        pend = 1;
        rem = lat;
      end
      if (!rst_n) pend = 0;
    end
  end

  // Output monitor: completions pop the scoreboard.
  always @(negedge clk) begin
    if (inv_start) begin
      istart_cnt++;
      t_istart = cyc;
      seen_a = inv_a;
      seen_b = inv_b;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done || err) begin
      t_end = cyc;
      chk("done_err_exclusive", {done, err} == 2'b11, 0);
      chk("expected_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        chk("kind_is_err", err, cur.is_err);
        chk("err_code", err_code, cur.code);
        chk("n", n, cur.n);
        chk("phi", phi, cur.phi);
        chk("d", d, cur.d);
      end
    end
  end

  task automatic wait_end();
    int k = 0;
    while (!(done || err) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("completion_within_budget", k < 2000, 1);
  endtask

  task automatic kick(input logic [7:0] tp, input logic [7:0] tq, input logic [7:0] te, input int tl, input exp_t x);
    @(negedge clk);
    p = tp;
    q = tq;
    e = te;
    lat = tl;
    start = 1;
    sb.push_back(x);
    t0 = cyc;
    @(negedge clk);
    start = 0;
    p = 8'($urandom);
    q = 8'($urandom);
    e = 8'($urandom);
  endtask

  task automatic zero_chk(input string tag);
    chk(tag, {busy, done, err, inv_start, err_code, n, phi, d, inv_a, inv_b}, 0);
  endtask

  initial begin
    int dc, ec, ic, k;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    zero_chk("reset_outputs");
    rst_n = 1;
    // 3,11,3: phi=20, d=7
    eng_val = 8'(inv_of(3, 20));
    dc = done_cnt; ic = istart_cnt;
    kick(3, 11, 3, 5, '{1'b0, 2'd0, 16'd33, 16'd20, 8'd7});
    wait_end();
    chk("c1_inv_a_at_start", seen_a, 3);
    chk("c1_inv_b_at_start", seen_b, 20);
    chk("c1_inv_a_at_done", done_a, 3);
    chk("c1_inv_b_at_done", done_b, 20);
    chk("c1_one_inv_start", istart_cnt - ic, 1);
    chk("c1_one_done", done_cnt - dc, 1);
    // stray inv_done in IDLE must not touch d
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_done_d_kept", d, 7);
    chk("stray_done_idle", {busy, done}, 0);
    // 5,7,5: phi=24, d=5; extra start while busy is dropped
    eng_val = 8'(inv_of(5, 24));
    dc = done_cnt;
    kick(5, 7, 5, 2, '{1'b0, 2'd0, 16'd35, 16'd24, 8'd5});
    @(negedge clk);
    start = 1; p = 3; q = 11; e = 3;
    @(negedge clk);
    start = 0;
    wait_end();
    chk("c2_gcd_latency", t_istart - t0, gcd_steps(5, 24) + 4);
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", busy, 0);
    chk("c2_one_done", done_cnt - dc, 1);
    // 3,11,4: gcd 4
    ic = istart_cnt;
    kick(3, 11, 4, 2, '{1'b1, 2'd2, 16'd33, 16'd20, 8'd0});
    wait_end();
    chk("c3_no_inv_start", istart_cnt - ic, 0);
    // invalid inputs
    kick(17, 19, 5, 2, '{1'b1, 2'd1, 16'd323, 16'd288, 8'd0});
    wait_end();
    kick(3, 11, 1, 2, '{1'b1, 2'd1, 16'd33, 16'd20, 8'd0});
    wait_end();
    // engine silent: ERR entered TO edges after inv_start is sampled
    kick(3, 11, 3, 0, '{1'b1, 2'd3, 16'd33, 16'd20, 8'd0});
    wait_end();
    chk("timeout_latency", t_end - t_istart, TO + 1);
    // engine answers in the last allowed wait cycle
    eng_val = 8'(inv_of(3, 20));
    kick(3, 11, 3, TO, '{1'b0, 2'd0, 16'd33, 16'd20, 8'd7});
    wait_end();
    chk("late_done_latency", t_end - t_istart, TO + 1);
    // start held high restarts from the IDLE cycle after done
    dc = done_cnt;
    @(negedge clk);
    sb.push_back('{1'b0, 2'd0, 16'd33, 16'd20, 8'd7});
    sb.push_back('{1'b0, 2'd0, 16'd33, 16'd20, 8'd7});
    p = 3; q = 11; e = 3; lat = 3; start = 1;
    wait_end();
    @(negedge clk);
    chk("held_start_idle_gap", busy, 0);
    @(negedge clk);
    chk("held_start_restart", busy, 1);
    start = 0;
    @(negedge clk);
    wait_end();
    chk("held_start_two_done", done_cnt - dc, 2);
    // reset during GCD
    dc = done_cnt; ec = err_cnt;
    kick(5, 7, 5, 2, '{1'b0, 2'd0, 16'd35, 16'd24, 8'd5});
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 zero_chk("reset_in_gcd");
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("reset_gcd_no_pulse", {done_cnt - dc, err_cnt - ec}, 0);
    // reset during INV_WAIT
    kick(3, 11, 3, 0, '{1'b1, 2'd3, 16'd33, 16'd20, 8'd0});
    k = 0;
    while (!inv_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_inv_start", k < 100, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1 zero_chk("reset_in_inv_wait");
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("reset_wait_no_pulse", {done_cnt - dc, err_cnt - ec}, 0);
    // clean run after reset
    eng_val = 8'(inv_of(3, 20));
    kick(3, 11, 3, 4, '{1'b0, 2'd0, 16'd33, 16'd20, 8'd7});
    wait_end();
    chk("post_reset_done", done_cnt - dc, 1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
